// File: rtl/jk_counter_bank.sv
// ============================================================================
// Module   : jk_counter_bank
// Brief    : WIDTH-bit modulo up/down counter, parallel load and raw JK mode,
//            all reduced to per-bit JK cells; terminal-count and sticky flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jk_counter_bank #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 256,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0]       MODE_HOLD  = 2'b00;
  localparam logic [1:0]       MODE_COUNT = 2'b01;
  localparam logic [1:0]       MODE_LOAD  = 2'b10;
  localparam logic [1:0]       MODE_JK    = 2'b11;

  // MOD_EXT is one bit wider so MODULUS == 2^WIDTH still compares correctly
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] state_q, state_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic             wrap;

  always_comb begin
    target = state_q;
    wrap   = 1'b0;
    j_vec  = '0;
    k_vec  = '0;
    if (en) begin
      case (mode)
        MODE_COUNT: begin
          if (up) begin
            if (state_q >= MAX_VAL) begin
              target = '0;
              wrap   = 1'b1;
            end else begin
              target = state_q + ONE;
            end
          end else begin
            if (state_q == '0) begin
              target = MAX_VAL;
              wrap   = 1'b1;
            end else if ({1'b0, state_q} >= MOD_EXT) begin
              target = MAX_VAL;
            end else begin
              target = state_q - ONE;
            end
          end
          j_vec = target ^ state_q;
          k_vec = target ^ state_q;
        end
        MODE_LOAD: begin
          target = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
          j_vec  = target;
          k_vec  = ~target;
        end
        MODE_JK: begin
          j_vec = j;
          k_vec = k;
        end
        default: begin
          j_vec = '0;
          k_vec = '0;
        end
      endcase
    end
  end

  // JK characteristic equation: Q+ = J&~Q | ~K&Q
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign state_d[i] = (j_vec[i] & ~state_q[i]) | (~k_vec[i] & state_q[i]);
  end

  always_comb begin
    tc_d  = wrap;
    ovf_d = ovf_q;
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = state_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
// ============================================================================
// Module   : tb_jk_counter_bank
// Brief    : Directed bench; instance a is MODULUS=10/RESET_VALUE=3, instance b
//            is full-range MODULUS=256. Both share the same stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jk_counter_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       up;
  logic [7:0] load_val;
  logic [7:0] j;
  logic [7:0] k;
  logic       clr_ovf;

  logic [7:0] q_a, q_b;
  logic       tc_a, tc_b;
  logic       ovf_a, ovf_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jk_counter_bank #(.WIDTH(8), .MODULUS(10), .RESET_VALUE(3)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .up(up),
    .load_val(load_val), .j(j), .k(k), .clr_ovf(clr_ovf),
    .q(q_a), .tc(tc_a), .ovf(ovf_a)
  );

  jk_counter_bank #(.WIDTH(8), .MODULUS(256), .RESET_VALUE(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .up(up),
    .load_val(load_val), .j(j), .k(k), .clr_ovf(clr_ovf),
    .q(q_b), .tc(tc_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b1; mode = 2'b00; up = 1'b1;
    load_val = '0; j = '0; k = '0; clr_ovf = 1'b0;

    // asynchronous reset before the first clock edge
    #3 reset = 1'b1;
    #1;
    chk("rst_q",   32'(q_a),   32'd3);
    chk("rst_tc",  32'(tc_a),  32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_q_b", 32'(q_b),   32'd0);
    tick; tick;
    reset = 1'b0;

    mode = 2'b10; load_val = 8'd0;
    tick;
    chk("load0_q",   32'(q_a),   32'd0);
    chk("load0_ovf", 32'(ovf_a), 32'd0);

    // up count through the wrap
    mode = 2'b01; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      chk("up_q",   32'(q_a),   32'(i % 10));
      chk("up_tc",  32'(tc_a),  32'(i == 10));
      chk("up_ovf", 32'(ovf_a), 32'(i >= 10));
    end

    // ovf clear without wrap, then clear colliding with a wrap
    mode = 2'b00; clr_ovf = 1'b1;
    tick;
    chk("clr_ovf",  32'(ovf_a), 32'd0);
    chk("hold_q",   32'(q_a),   32'd2);
    mode = 2'b10; load_val = 8'd9; clr_ovf = 1'b0;
    tick;
    chk("load9_q", 32'(q_a), 32'd9);
    mode = 2'b01; up = 1'b1; clr_ovf = 1'b1;
    tick;
    chk("setwin_q",   32'(q_a),   32'd0);
    chk("setwin_tc",  32'(tc_a),  32'd1);
    chk("setwin_ovf", 32'(ovf_a), 32'd1);
    clr_ovf = 1'b0;

    // down wrap and load clamp
    mode = 2'b10; load_val = 8'd0;
    tick;
    chk("load_no_tc", 32'(tc_a), 32'd0);
    mode = 2'b01; up = 1'b0;
    tick;
    chk("down_q",  32'(q_a),  32'd9);
    chk("down_tc", 32'(tc_a), 32'd1);
    mode = 2'b10; load_val = 8'd15;
    tick;
    chk("clamp_q",  32'(q_a),  32'd9);
    chk("clamp_tc", 32'(tc_a), 32'd0);

    // reset mid-count, asserted between edges
    load_val = 8'd6;
    tick;
    mode = 2'b01; up = 1'b1;
    tick;
    chk("pre_rst_q", 32'(q_a), 32'd7);
    #2 reset = 1'b1;
    #1;
    chk("midrst_q",   32'(q_a),   32'd3);
    chk("midrst_tc",  32'(tc_a),  32'd0);
    chk("midrst_ovf", 32'(ovf_a), 32'd0);
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_q", 32'(q_a), 32'd4);

    // raw JK access
    mode = 2'b11; j = 8'h0F; k = 8'hF0;
    tick;
    chk("jk_setup_q", 32'(q_a), 32'h0F);
    j = 8'hF0; k = 8'h3C;
    tick;
    chk("jk_q",  32'(q_a),  32'hF3);
    chk("jk_tc", 32'(tc_a), 32'd0);
    mode = 2'b01; up = 1'b1;
    tick;
    chk("oor_up_q",  32'(q_a),  32'd0);
    chk("oor_up_tc", 32'(tc_a), 32'd1);
    mode = 2'b11; j = 8'hF3; k = 8'h0C;
    tick;
    chk("jk2_q", 32'(q_a), 32'hF3);
    mode = 2'b01; up = 1'b0;
    tick;
    chk("oor_dn_q",  32'(q_a),  32'd9);
    chk("oor_dn_tc", 32'(tc_a), 32'd0);

    // enable low: hold, no tc, clr_ovf still works
    en = 1'b0; mode = 2'b01; up = 1'b1; clr_ovf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("en0_q",  32'(q_a),  32'd9);
      chk("en0_tc", 32'(tc_a), 32'd0);
    end
    chk("en0_ovf", 32'(ovf_a), 32'd0);
    clr_ovf = 1'b0;

    // full-range instance
    en = 1'b1; mode = 2'b10; load_val = 8'd255;
    tick;
    chk("b_load_q", 32'(q_b), 32'd255);
    chk("a_clamp2", 32'(q_a), 32'd9);
    en = 1'b0; mode = 2'b01; up = 1'b1; clr_ovf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("b_en0_q",  32'(q_b),  32'd255);
      chk("b_en0_tc", 32'(tc_b), 32'd0);
    end
    chk("b_en0_ovf", 32'(ovf_b), 32'd0);
    clr_ovf = 1'b0;
    en = 1'b1;
    tick;
    chk("b_wrap_q",   32'(q_b),   32'd0);
    chk("b_wrap_tc",  32'(tc_b),  32'd1);
    chk("b_wrap_ovf", 32'(ovf_b), 32'd1);
    mode = 2'b00;
    tick;
    chk("b_tc_pulse", 32'(tc_b),  32'd0);
    chk("b_sticky",   32'(ovf_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
